multicycle_maindec: RTL and testbench
=====================================

// Module: multicycle_maindec
// PURPOSE
//  Multicycle MIPS control FSM. Successor to the single-cycle main decoder: same opcode set (R, lw, sw,
//  beq, addi, j), optional bne, and a ready handshake on the shared instr/data memory.
//  Sits in the multicycle datapath top. Drives the PC, IR, register-file, ALU-mux and memory strobes.
//  Also keeps a retired-instruction counter.
// PARAMETERS
//  EN_BNE   1   1: opcode 000101 (bne) decoded as branch-not-equal; 0: bne is illegal
//  CNT_W    32  width of instret counter
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  opcode       in   6      IR[31:26]; stable from DECODE until return to FETCH
//  mem_rdy      in   1      memory completes the current access this cycle
//  mem_req      out  1      memory access request
//  iord         out  1      0: address = PC; 1: address = ALUOut
//  memwrite     out  1      write strobe (qualifies mem_req)
//  irwrite      out  1      load IR
//  pcwrite      out  1      unconditional PC load
//  branch       out  1      conditional PC load
//  branch_ne    out  1      1: branch on !zero; 0: branch on zero
//  alusrca      out  1      0: PC; 1: register A
//  alusrcb      out  2      00 regB, 01 const 4, 10 signimm, 11 signimm<<2
//  aluop        out  2      00 add, 01 sub, 10 use funct
//  pcsrc        out  2      00 ALU result, 01 ALUOut, 10 jump target
//  regdst       out  1      0: rt; 1: rd
//  memtoreg     out  1      0: ALUOut; 1: MDR
//  regwrite     out  1      register-file write
//  illegal_op   out  1      1-cycle pulse: unknown opcode in DECODE
//  instr_done   out  1      1-cycle pulse: instruction retires
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - State register and instret are reset asynchronously to FETCH and 0.
//  - While rst is high, every strobe and mux output is 0.
//  - Outputs decode from state (Moore), except where gated by mem_rdy (noted below).
//  - Every output not listed for a state is 0.
//  - FETCH: mem_req, iord=0, alusrcb=01.
//    Stays in FETCH while !mem_rdy. When mem_rdy: irwrite=1, pcwrite=1, go to DECODE.
//  - DECODE: alusrcb=11 (branch target into ALUOut). Next state by opcode:
//    100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX;
//    000101 -> BEQEX if EN_BNE; 001000 -> ADDIEX; 000010 -> JEX.
//    Any other opcode: illegal_op=1, no retire, go to FETCH.
//  - MEMADR: alusrca=1, alusrcb=10. Go to MEMRD for lw, MEMWR for sw.
//  - MEMRD: mem_req, iord=1. Holds until mem_rdy, then go to MEMWB.
//  - MEMWB: memtoreg=1, regwrite=1, retire, go to FETCH.
//  - MEMWR: mem_req, iord=1, memwrite=1, all held until mem_rdy. Retire in the mem_rdy cycle, go to FETCH.
//  - RTYPEEX: alusrca=1, aluop=10. Go to RTYPEWB.
//  - RTYPEWB: regdst=1, regwrite=1, retire, go to FETCH.
//  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1, branch_ne=(opcode==000101). Retire, go to FETCH.
//  - ADDIEX: alusrca=1, alusrcb=10. Go to ADDIWB.
//  - ADDIWB: regwrite=1, retire, go to FETCH.
//  - JEX: pcsrc=10, pcwrite=1, retire, go to FETCH.
//  - Retire: instr_done=1 in that cycle; instret+1 at the clock edge. instret wraps 2^CNT_W-1 -> 0.
//  - Cycle counts with mem_rdy tied high: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3, illegal 2.
//  - mem_rdy is ignored outside FETCH/MEMRD/MEMWR. Wait states are unbounded; no timeout.
//  - rst mid-instruction: state returns to FETCH immediately and no partial strobe is emitted.
//    instret clears; an in-flight instruction is not counted.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J),
//    state encodings (4-bit), and the alusrcb/aluop/pcsrc encodings.
//  - Single module. Output decode is one case on state. No sub-module needed.
//  - aludec is unchanged and consumes aluop.
// TESTING
//  1. rst high 3 cycles, mem_rdy=1: all outputs 0, instret=0.
//     After release, FETCH with mem_req=1; DECODE next cycle.
//  2. lw (100011), mem_rdy=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB.
//     regwrite=1 and memtoreg=1 in cycle 5; instret 0 -> 1.
//  3. sw with mem_rdy low for 3 cycles in MEMWR: memwrite+iord+mem_req held 4 cycles.
//     instr_done pulses once; regwrite never asserted.
//  4. bne (000101) with EN_BNE=1: BEQEX asserts branch=1, branch_ne=1, pcsrc=01.
//     Same opcode with EN_BNE=0: illegal_op pulse, instret unchanged.
//  5. Opcode 111111: illegal_op=1 in DECODE, back to FETCH next cycle.
//  6. CNT_W=4: 16 j instructions -> instret wraps 15 -> 0. rst asserted during RTYPEEX:
//     regwrite never pulses, instret reads 0 in the cycle after rst rises.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, state and control-field encodings for the multicycle MIPS controller
//
// Purpose : shared constants for multicycle_maindec and its datapath neighbours.
// Contents: opcode constants, 4-bit FSM state encoding, alusrcb/aluop/pcsrc
//           encodings and the packed control-word struct driven by the FSM.
package mips_ctrl_pkg;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // ALU operation class handed to aludec
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // One field per controller output; an all-zero word is the idle/reset value.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_maindec.sv
// rtl/multicycle_maindec.sv - multicycle MIPS control FSM with memory ready handshake and instret counter
//
// Purpose : sequences FETCH/DECODE/execute/writeback for R, lw, sw, beq, (bne), addi, j
//           and counts retired instructions.
// Ports   : clk, rst (async, active high)
//           opcode      IR[31:26], stable from DECODE until the return to FETCH
//           mem_rdy     shared memory completes the current access this cycle
//           mem_req, iord, memwrite          memory strobes / address select
//           irwrite, pcwrite, branch, branch_ne, pcsrc   IR and PC control
//           alusrca, alusrcb, aluop          ALU operand and operation select
//           regdst, memtoreg, regwrite       register-file control
//           illegal_op  one-cycle pulse on an unknown opcode in DECODE
//           instr_done  one-cycle pulse when an instruction retires
//           instret     retired-instruction count, wraps at 2^CNT_W
module multicycle_maindec #(
    parameter bit EN_BNE = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             branch,
    output logic             branch_ne,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret
);

    import mips_ctrl_pkg::*;

    state_t state, state_nxt;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        ctrl      = '0;
        state_nxt = state;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b0;
                ctrl.alusrcb = SRCB_FOUR;
                // IR and PC load only in the cycle the instruction word arrives
                if (mem_rdy) begin
                    ctrl.irwrite = 1'b1;
                    ctrl.pcwrite = 1'b1;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding
                ctrl.alusrcb = SRCB_IMMSH;
                state_nxt    = S_FETCH;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTYPEEX;
                    OP_BEQ:       state_nxt = S_BEQEX;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JEX;
                    OP_BNE: begin
                        if (EN_BNE) begin
                            state_nxt = S_BEQEX;
                        end else begin
                            ctrl.illegal_op = 1'b1;
                        end
                    end
                    default:      ctrl.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                state_nxt    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_rdy) begin
                    state_nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_MEMWR: begin
                // Strobes held through wait states; retire with the accepting cycle
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                if (mem_rdy) begin
                    ctrl.instr_done = 1'b1;
                    state_nxt       = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_FUNCT;
                state_nxt    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_BEQEX: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_REGB;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.branch_ne  = (opcode == OP_BNE);
                ctrl.instr_done = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
                state_nxt    = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_JEX: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nxt       = S_FETCH;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // The state register already sits at FETCH during reset, whose mem_req would
    // otherwise leak out; force the whole control word idle while rst is high.
    assign ctrl_out = rst ? '0 : ctrl;

    assign mem_req    = ctrl_out.mem_req;
    assign iord       = ctrl_out.iord;
    assign memwrite   = ctrl_out.memwrite;
    assign irwrite    = ctrl_out.irwrite;
    assign pcwrite    = ctrl_out.pcwrite;
    assign branch     = ctrl_out.branch;
    assign branch_ne  = ctrl_out.branch_ne;
    assign alusrca    = ctrl_out.alusrca;
    assign alusrcb    = ctrl_out.alusrcb;
    assign aluop      = ctrl_out.aluop;
    assign pcsrc      = ctrl_out.pcsrc;
    assign regdst     = ctrl_out.regdst;
    assign memtoreg   = ctrl_out.memtoreg;
    assign regwrite   = ctrl_out.regwrite;
    assign illegal_op = ctrl_out.illegal_op;
    assign instr_done = ctrl_out.instr_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (ctrl.instr_done) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_maindec.sv
// tb/tb_multicycle_maindec.sv - directed self-checking bench for multicycle_maindec
module tb_multicycle_maindec;

    import mips_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: EN_BNE=1, CNT_W=32
    logic        rst, mem_rdy;
    logic [5:0]  opcode;
    logic        mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_ne, alusrca;
    logic [1:0]  alusrcb, aluop, pcsrc;
    logic        regdst, memtoreg, regwrite, illegal_op, instr_done;
    logic [31:0] instret;

    // Instance B: EN_BNE=0, CNT_W=4
    logic        rst2, mem_rdy2;
    logic [5:0]  opcode2;
    logic        b_mem_req, b_iord, b_memwrite, b_irwrite, b_pcwrite, b_branch, b_branch_ne, b_alusrca;
    logic [1:0]  b_alusrcb, b_aluop, b_pcsrc;
    logic        b_regdst, b_memtoreg, b_regwrite, b_illegal_op, b_instr_done;
    logic [3:0]  instret2;

    multicycle_maindec #(.EN_BNE(1'b1), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .illegal_op(illegal_op),
        .instr_done(instr_done), .instret(instret)
    );

    multicycle_maindec #(.EN_BNE(1'b0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst2), .opcode(opcode2), .mem_rdy(mem_rdy2),
        .mem_req(b_mem_req), .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite),
        .pcwrite(b_pcwrite), .branch(b_branch), .branch_ne(b_branch_ne), .alusrca(b_alusrca),
        .alusrcb(b_alusrcb), .aluop(b_aluop), .pcsrc(b_pcsrc), .regdst(b_regdst),
        .memtoreg(b_memtoreg), .regwrite(b_regwrite), .illegal_op(b_illegal_op),
        .instr_done(b_instr_done), .instret(instret2)
    );

    // {mem_req,iord,memwrite,irwrite,pcwrite,branch,branch_ne,alusrca, alusrcb, aluop, pcsrc,
    //  regdst,memtoreg,regwrite,illegal_op,instr_done}
    logic [18:0] obs, obs2;
    assign obs  = {mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_ne, alusrca,
                   alusrcb, aluop, pcsrc, regdst, memtoreg, regwrite, illegal_op, instr_done};
    assign obs2 = {b_mem_req, b_iord, b_memwrite, b_irwrite, b_pcwrite, b_branch, b_branch_ne, b_alusrca,
                   b_alusrcb, b_aluop, b_pcsrc, b_regdst, b_memtoreg, b_regwrite, b_illegal_op, b_instr_done};

    localparam logic [18:0] E_ZERO       = '0;
    localparam logic [18:0] E_FETCH_WAIT = {8'b1000_0000, 2'b01, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_FETCH_RDY  = {8'b1001_1000, 2'b01, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_DECODE     = {8'b0000_0000, 2'b11, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_ILLEGAL    = {8'b0000_0000, 2'b11, 2'b00, 2'b00, 5'b00010};
    localparam logic [18:0] E_MEMADR     = {8'b0000_0001, 2'b10, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_MEMRD      = {8'b1100_0000, 2'b00, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_MEMWB      = {8'b0000_0000, 2'b00, 2'b00, 2'b00, 5'b01101};
    localparam logic [18:0] E_MEMWR_WAIT = {8'b1110_0000, 2'b00, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_MEMWR_RDY  = {8'b1110_0000, 2'b00, 2'b00, 2'b00, 5'b00001};
    localparam logic [18:0] E_RTYPEEX    = {8'b0000_0001, 2'b00, 2'b10, 2'b00, 5'b00000};
    localparam logic [18:0] E_RTYPEWB    = {8'b0000_0000, 2'b00, 2'b00, 2'b00, 5'b10101};
    localparam logic [18:0] E_BEQ        = {8'b0000_0101, 2'b00, 2'b01, 2'b01, 5'b00001};
    localparam logic [18:0] E_BNE        = {8'b0000_0111, 2'b00, 2'b01, 2'b01, 5'b00001};
    localparam logic [18:0] E_ADDIEX     = {8'b0000_0001, 2'b10, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_ADDIWB     = {8'b0000_0000, 2'b00, 2'b00, 2'b00, 5'b00101};
    localparam logic [18:0] E_JEX        = {8'b0000_1000, 2'b00, 2'b00, 2'b10, 5'b00001};

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_ret;
    logic [3:0]  exp_ret2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_rdy = 1'b1; opcode = OP_J;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== E_ZERO) begin
                errors++; $display("FAIL reset_outputs cyc=%0d got=%h want=%h", i, obs, E_ZERO);
            end
            checks++;
            if (instret !== 32'd0) begin
                errors++; $display("FAIL reset_instret cyc=%0d got=%0d want=0", i, instret);
            end
            tick;
        end
        rst = 1'b0; #1;
        checks++;
        if (obs !== E_FETCH_RDY) begin
            errors++; $display("FAIL post_reset_fetch got=%h want=%h", obs, E_FETCH_RDY);
        end
        tick; #1;
        checks++;
        if (obs !== E_DECODE) begin
            errors++; $display("FAIL post_reset_decode got=%h want=%h", obs, E_DECODE);
        end
        tick; #1;
        checks++;
        if (obs !== E_JEX) begin
            errors++; $display("FAIL first_jex got=%h want=%h", obs, E_JEX);
        end
        tick; #1;
        exp_ret = 32'd1;
        checks++;
        if (instret !== exp_ret) begin
            errors++; $display("FAIL first_retire got=%0d want=%0d", instret, exp_ret);
        end
    endtask

    task automatic test_lw;
        logic [18:0] seq [5];
        seq = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
        opcode = OP_LW; mem_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (obs !== seq[i]) begin
                errors++; $display("FAIL lw_cycle%0d got=%h want=%h", i + 1, obs, seq[i]);
            end
            tick;
        end
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (instret !== exp_ret) begin
            errors++; $display("FAIL lw_instret got=%0d want=%0d", instret, exp_ret);
        end
    endtask

    task automatic test_sw_wait;
        logic [18:0] seq [8];
        logic        rdy [8];
        int          done_cnt = 0;
        int          rw_cnt = 0;
        seq = '{E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_MEMADR,
                E_MEMWR_WAIT, E_MEMWR_WAIT, E_MEMWR_WAIT, E_MEMWR_RDY};
        rdy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = OP_SW;
        for (int i = 0; i < 8; i++) begin
            mem_rdy = rdy[i];
            #1;
            if (instr_done) done_cnt++;
            if (regwrite) rw_cnt++;
            checks++;
            if (obs !== seq[i]) begin
                errors++; $display("FAIL sw_cycle%0d got=%h want=%h", i, obs, seq[i]);
            end
            tick;
        end
        mem_rdy = 1'b1;
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL sw_done_pulses got=%0d want=1", done_cnt);
        end
        checks++;
        if (rw_cnt !== 0) begin
            errors++; $display("FAIL sw_regwrite got=%0d want=0", rw_cnt);
        end
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (instret !== exp_ret) begin
            errors++; $display("FAIL sw_instret got=%0d want=%0d", instret, exp_ret);
        end
    endtask

    task automatic test_rtype_addi;
        logic [18:0] seq [8];
        logic [5:0]  ops [8];
        seq = '{E_FETCH_RDY, E_DECODE, E_RTYPEEX, E_RTYPEWB,
                E_FETCH_RDY, E_DECODE, E_ADDIEX, E_ADDIWB};
        ops = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
        mem_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            opcode = ops[i];
            #1;
            checks++;
            if (obs !== seq[i]) begin
                errors++; $display("FAIL rtype_addi_cycle%0d got=%h want=%h", i, obs, seq[i]);
            end
            tick;
        end
        exp_ret = exp_ret + 32'd2;
        checks++;
        if (instret !== exp_ret) begin
            errors++; $display("FAIL rtype_addi_instret got=%0d want=%0d", instret, exp_ret);
        end
    endtask

    task automatic test_branch;
        logic [18:0] seq [6];
        logic [5:0]  ops [6];
        seq = '{E_FETCH_RDY, E_DECODE, E_BEQ, E_FETCH_RDY, E_DECODE, E_BNE};
        ops = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_BNE};
        mem_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            #1;
            checks++;
            if (obs !== seq[i]) begin
                errors++; $display("FAIL branch_cycle%0d got=%h want=%h", i, obs, seq[i]);
            end
            tick;
        end
        exp_ret = exp_ret + 32'd2;
        checks++;
        if (instret !== exp_ret) begin
            errors++; $display("FAIL branch_instret got=%0d want=%0d", instret, exp_ret);
        end
    endtask

    task automatic test_illegal;
        opcode = 6'b111111; mem_rdy = 1'b1;
        #1;
        checks++;
        if (obs !== E_FETCH_RDY) begin
            errors++; $display("FAIL illegal_fetch got=%h want=%h", obs, E_FETCH_RDY);
        end
        tick; #1;
        checks++;
        if (obs !== E_ILLEGAL) begin
            errors++; $display("FAIL illegal_decode got=%h want=%h", obs, E_ILLEGAL);
        end
        tick; #1;
        checks++;
        if (obs !== E_FETCH_RDY) begin
            errors++; $display("FAIL illegal_back_to_fetch got=%h want=%h", obs, E_FETCH_RDY);
        end
        checks++;
        if (instret !== exp_ret) begin
            errors++; $display("FAIL illegal_instret got=%0d want=%0d", instret, exp_ret);
        end
    endtask

    task automatic test_bne_disabled;
        mem_rdy2 = 1'b1; opcode2 = OP_BNE;
        rst2 = 1'b0; #1;
        checks++;
        if (obs2 !== E_FETCH_RDY) begin
            errors++; $display("FAIL nobne_fetch got=%h want=%h", obs2, E_FETCH_RDY);
        end
        tick; #1;
        checks++;
        if (obs2 !== E_ILLEGAL) begin
            errors++; $display("FAIL nobne_illegal got=%h want=%h", obs2, E_ILLEGAL);
        end
        tick; #1;
        checks++;
        if (obs2 !== E_FETCH_RDY) begin
            errors++; $display("FAIL nobne_back_to_fetch got=%h want=%h", obs2, E_FETCH_RDY);
        end
        checks++;
        if (instret2 !== 4'd0) begin
            errors++; $display("FAIL nobne_instret got=%0d want=0", instret2);
        end
    endtask

    task automatic test_wrap;
        opcode2 = OP_J; mem_rdy2 = 1'b1;
        exp_ret2 = 4'd0;
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < 3; c++) tick;
            exp_ret2 = exp_ret2 + 4'd1;
            checks++;
            if (instret2 !== exp_ret2) begin
                errors++; $display("FAIL wrap_j%0d got=%0d want=%0d", n + 1, instret2, exp_ret2);
            end
        end
        checks++;
        if (instret2 !== 4'd0) begin
            errors++; $display("FAIL wrap_to_zero got=%0d want=0", instret2);
        end
    endtask

    task automatic test_rst_mid;
        int rw_cnt = 0;
        opcode = OP_RTYPE; mem_rdy = 1'b1;
        #1;
        tick; tick; #1;
        checks++;
        if (obs !== E_RTYPEEX) begin
            errors++; $display("FAIL rstmid_rtypeex got=%h want=%h", obs, E_RTYPEEX);
        end
        checks++;
        if (instret !== exp_ret) begin
            errors++; $display("FAIL rstmid_pre_instret got=%0d want=%0d", instret, exp_ret);
        end
        rst = 1'b1; #1;
        if (regwrite) rw_cnt++;
        checks++;
        if (obs !== E_ZERO) begin
            errors++; $display("FAIL rstmid_outputs got=%h want=%h", obs, E_ZERO);
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++; $display("FAIL rstmid_instret got=%0d want=0", instret);
        end
        tick;
        if (regwrite) rw_cnt++;
        rst = 1'b0; #1;
        checks++;
        if (obs !== E_FETCH_RDY) begin
            errors++; $display("FAIL rstmid_refetch got=%h want=%h", obs, E_FETCH_RDY);
        end
        tick; #1;
        if (regwrite) rw_cnt++;
        checks++;
        if (obs !== E_DECODE) begin
            errors++; $display("FAIL rstmid_redecode got=%h want=%h", obs, E_DECODE);
        end
        checks++;
        if (rw_cnt !== 0) begin
            errors++; $display("FAIL rstmid_regwrite got=%0d want=0", rw_cnt);
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++; $display("FAIL rstmid_post_instret got=%0d want=0", instret);
        end
    endtask

    initial begin
        rst = 1'b0; rst2 = 1'b0;
        mem_rdy = 1'b1; mem_rdy2 = 1'b1;
        opcode = OP_J; opcode2 = OP_J;
        exp_ret = '0; exp_ret2 = '0;
        #1;
        rst = 1'b1; rst2 = 1'b1;
        test_reset;
        test_lw;
        test_sw_wait;
        test_rtype_addi;
        test_branch;
        test_illegal;
        test_bne_disabled;
        test_wrap;
        test_rst_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
